mips_prog_loader: RTL and testbench

- Upstream feeder for pipe_MIPS32: streams 32-bit instruction words into the processor's instruction/data memory, then releases the core to run from address 0.
- Replaces hand-poking of Mem[] and HALTED/PC/TAKEN_BRANCH.
- Words arrive over a valid/ready stream. Writes go to memory sequentially from address 0.
- The stream ends on an explicit last flag or on a HLT opcode. The loader then pulses a start strobe to the core.

---
 rtl/mips_prog_loader.sv | 130 +++++++++++++
 tb/tb_mips_prog_loader.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : mips_prog_loader
// Description : Streams 32-bit instruction words from a valid/ready source
//               into the pipe_MIPS32 instruction memory from address 0, holds
//               the core while loading, and then releases it with a one-cycle
//               start strobe. The load ends on in_last or on a HLT opcode.
//               Running out of space without a terminator is an error.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_prog_loader #(
    parameter int         ADDR_W    = 10,
    parameter int         MAX_WORDS = 1024,
    parameter logic [5:0] HLT_OP    = 6'h3f
) (
    input  logic              clk1,
    input  logic              reset,
    input  logic              load_req,
    input  logic              in_valid,
    input  logic [31:0]       in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              cpu_start,
    output logic [ADDR_W:0]   word_count,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_RELEASE = 3'd2,
        S_DONE    = 3'd3,
        S_ERR     = 3'd4
    } state_t;

    // Address of the last word that fits; a non-terminating word here overflows.
    localparam logic [ADDR_W-1:0] C_LAST_PTR = ADDR_W'(MAX_WORDS - 1);
    localparam logic [ADDR_W-1:0] C_PTR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   C_CNT_ONE  = (ADDR_W + 1)'(1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic              w_fire;
    logic              w_term;

    // Ready depends on state alone so the source never sees a valid->ready loop.
    assign in_ready = (r_state == S_LOAD);
    assign w_fire   = in_valid && in_ready;
    // Either terminator ends the load; both together are still one terminator.
    assign w_term   = in_last || (in_data[31:26] == HLT_OP);

    // Loader FSM with registered memory-write and core-control outputs.
    always_ff @(posedge clk1) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_hold   <= 1'b1;
            cpu_start  <= 1'b0;
            word_count <= '0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            mem_we    <= 1'b0;
            cpu_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    cpu_hold <= 1'b1;
                    if (load_req) begin
                        word_count <= '0;
                        r_ptr      <= '0;
                        r_state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (w_fire) begin
                        mem_we     <= 1'b1;
                        mem_addr   <= r_ptr;
                        mem_wdata  <= in_data;
                        r_ptr      <= r_ptr + C_PTR_ONE;
                        word_count <= word_count + C_CNT_ONE;
                        if (w_term) begin
                            r_state <= S_RELEASE;
                        end else if (r_ptr == C_LAST_PTR) begin
                            error   <= 1'b1;
                            r_state <= S_ERR;
                        end
                    end
                end
                S_RELEASE: begin
                    // The final write committed on this edge; the core may fetch now.
                    cpu_hold  <= 1'b0;
                    cpu_start <= 1'b1;
                    r_state   <= S_DONE;
                end
                S_DONE: begin
                    if (load_req) begin
                        // Halt the core again before overwriting its program.
                        cpu_hold   <= 1'b1;
                        done       <= 1'b0;
                        word_count <= '0;
                        r_ptr      <= '0;
                        r_state    <= S_LOAD;
                    end else begin
                        cpu_hold <= 1'b0;
                        done     <= 1'b1;
                    end
                end
                S_ERR: begin
                    // Sticky until reset; the core stays halted.
                    error    <= 1'b1;
                    cpu_hold <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mips_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_prog_loader
// Description : Directed self-checking bench for mips_prog_loader. A default
//               build and a 4-word build are exercised side by side.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_prog_loader;

    logic        clk1 = 1'b0;
    logic        reset, reset4, load_req, load_req4;
    logic        in_valid, in_last;
    logic [31:0] in_data;

    logic        in_ready, mem_we, cpu_hold, cpu_start, done, error;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [10:0] word_count;

    logic        in_ready4, mem_we4, cpu_hold4, cpu_start4, done4, error4;
    logic [1:0]  mem_addr4;
    logic [31:0] mem_wdata4;
    logic [2:0]  word_count4;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          start4_n = 0;
    int          we_cyc[$];
    int          fire_cyc[$];
    int          start_cyc[$];
    logic [9:0]  wr_addr[$];
    logic [31:0] wr_data[$];
    logic [1:0]  wr4_addr[$];
    logic [31:0] prog[16];

    mips_prog_loader dut (
        .clk1(clk1), .reset(reset), .load_req(load_req),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .cpu_hold(cpu_hold), .cpu_start(cpu_start),
        .word_count(word_count), .done(done), .error(error)
    );

    mips_prog_loader #(.ADDR_W(2), .MAX_WORDS(4)) dut4 (
        .clk1(clk1), .reset(reset4), .load_req(load_req4),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready4), .mem_we(mem_we4), .mem_addr(mem_addr4),
        .mem_wdata(mem_wdata4), .cpu_hold(cpu_hold4), .cpu_start(cpu_start4),
        .word_count(word_count4), .done(done4), .error(error4)
    );

    always #5 clk1 = ~clk1;

    always @(posedge clk1) cyc <= cyc + 1;

    // Record every write and start pulse with the edge number that produced it.
    always @(negedge clk1) begin
        if (mem_we) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
            we_cyc.push_back(cyc);
        end
        if (cpu_start) start_cyc.push_back(cyc);
        if (mem_we4) wr4_addr.push_back(mem_addr4);
        if (cpu_start4) start4_n++;
    end

    task automatic tick();
        @(posedge clk1);
        @(negedge clk1);
    endtask

    task automatic clear_logs();
        we_cyc.delete(); fire_cyc.delete(); start_cyc.delete();
        wr_addr.delete(); wr_data.delete(); wr4_addr.delete();
        start4_n = 0;
    endtask

    task automatic load_demo();
        prog[0] = 32'h2801000a; prog[1] = 32'h28020014; prog[2] = 32'h28030019;
        prog[3] = 32'h0ce77800; prog[4] = 32'h0ce77800; prog[5] = 32'h00222000;
        prog[6] = 32'h0ce77800; prog[7] = 32'h00832800; prog[8] = 32'hfc000000;
    endtask

    task automatic pulse_load(input bit sel4);
        if (sel4) load_req4 = 1'b1; else load_req = 1'b1;
        tick();
        load_req = 1'b0; load_req4 = 1'b0;
    endtask

    // Present prog[0..n-1]; records the edge on which each word is accepted.
    task automatic stream(input int n, input int last_at, input bit toggle, input bit sel4);
        int  i = 0;
        int  budget = 0;
        bit  ph = 1'b1;
        while (i < n && budget < 200) begin
            in_valid = toggle ? ph : 1'b1;
            ph       = ~ph;
            in_data  = prog[i];
            in_last  = (i == last_at);
            if (in_valid && (sel4 ? in_ready4 : in_ready)) begin
                fire_cyc.push_back(cyc + 1);
                i++;
            end
            tick();
            budget++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        checks++;
        if (i != n) begin
            errors++;
            $display("FAIL stream_timeout accepted %0d need %0d", i, n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; reset4 = 1'b1;
        tick(); tick();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we got %b exp 0", mem_we); end
        checks++; if (mem_addr !== 10'd0 || mem_wdata !== 32'd0) begin errors++; $display("FAIL rst_mem got %h/%h exp 0/0", mem_addr, mem_wdata); end
        checks++; if (cpu_hold !== 1'b1 || cpu_start !== 1'b0) begin errors++; $display("FAIL rst_cpu got %b%b exp 10", cpu_hold, cpu_start); end
        checks++; if (word_count !== 11'd0 || done !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL rst_status got %0d %b %b exp 0 0 0", word_count, done, error); end
        checks++; if (cpu_hold4 !== 1'b1 || error4 !== 1'b0) begin errors++; $display("FAIL rst4 got %b %b exp 1 0", cpu_hold4, error4); end
        reset = 1'b0; reset4 = 1'b0;
        tick();
    endtask

    task automatic test_hlt_load(input bit toggle, input string tag);
        load_demo();
        clear_logs();
        pulse_load(1'b0);
        checks++; if (in_ready !== 1'b1 || cpu_hold !== 1'b1) begin errors++; $display("FAIL %s_enter got ready=%b hold=%b exp 1 1", tag, in_ready, cpu_hold); end
        stream(9, -1, toggle, 1'b0);
        repeat (4) tick();
        checks++; if (wr_addr.size() != 9) begin errors++; $display("FAIL %s_nwrites got %0d exp 9", tag, wr_addr.size()); end
        for (int i = 0; i < 9 && i < wr_addr.size() && i < fire_cyc.size(); i++) begin
            checks++;
            if (wr_addr[i] !== 10'(i) || wr_data[i] !== prog[i]) begin
                errors++; $display("FAIL %s_write%0d got %h:%h exp %h:%h", tag, i, wr_addr[i], wr_data[i], 10'(i), prog[i]);
            end
            checks++;
            if (we_cyc[i] != fire_cyc[i]) begin
                errors++; $display("FAIL %s_we_timing%0d got edge %0d exp %0d", tag, i, we_cyc[i], fire_cyc[i]);
            end
        end
        checks++; if (word_count !== 11'd9) begin errors++; $display("FAIL %s_count got %0d exp 9", tag, word_count); end
        checks++; if (start_cyc.size() != 1) begin errors++; $display("FAIL %s_nstart got %0d exp 1", tag, start_cyc.size()); end
        if (start_cyc.size() == 1 && we_cyc.size() == 9) begin
            checks++; if (start_cyc[0] != we_cyc[8] + 1) begin errors++; $display("FAIL %s_start_time got %0d exp %0d", tag, start_cyc[0], we_cyc[8] + 1); end
        end
        checks++; if (done !== 1'b1 || cpu_hold !== 1'b0 || error !== 1'b0 || in_ready !== 1'b0) begin
            errors++; $display("FAIL %s_final got done=%b hold=%b err=%b rdy=%b exp 1 0 0 0", tag, done, cpu_hold, error, in_ready);
        end
    endtask

    task automatic test_last3();
        prog[0] = 32'h2801000a; prog[1] = 32'h28020014; prog[2] = 32'h00222000;
        clear_logs();
        pulse_load(1'b0);
        stream(3, 2, 1'b0, 1'b0);
        repeat (4) tick();
        checks++; if (word_count !== 11'd3) begin errors++; $display("FAIL last3_count got %0d exp 3", word_count); end
        checks++; if (wr_data.size() != 3 || (wr_data.size() == 3 && wr_data[2] !== 32'h00222000)) begin errors++; $display("FAIL last3_writes got %0d writes exp 3", wr_data.size()); end
        checks++; if (start_cyc.size() != 1) begin errors++; $display("FAIL last3_nstart got %0d exp 1", start_cyc.size()); end
        checks++; if (done !== 1'b1 || error !== 1'b0) begin errors++; $display("FAIL last3_final got done=%b err=%b exp 1 0", done, error); end
    endtask

    task automatic test_overflow();
        prog[0] = 32'h11111111; prog[1] = 32'h22222222; prog[2] = 32'h33333333; prog[3] = 32'h44444444;
        clear_logs();
        pulse_load(1'b1);
        stream(4, -1, 1'b0, 1'b1);
        repeat (4) tick();
        checks++; if (wr4_addr.size() != 4 || (wr4_addr.size() == 4 && wr4_addr[3] !== 2'd3)) begin errors++; $display("FAIL ovf_writes got %0d writes exp 4", wr4_addr.size()); end
        checks++; if (error4 !== 1'b1 || cpu_hold4 !== 1'b1 || done4 !== 1'b0) begin errors++; $display("FAIL ovf_status got err=%b hold=%b done=%b exp 1 1 0", error4, cpu_hold4, done4); end
        checks++; if (start4_n != 0) begin errors++; $display("FAIL ovf_start got %0d exp 0", start4_n); end
        checks++; if (word_count4 !== 3'd4) begin errors++; $display("FAIL ovf_count got %0d exp 4", word_count4); end
        checks++; if (wr_addr.size() != 0) begin errors++; $display("FAIL idle_ignores_valid got %0d writes exp 0", wr_addr.size()); end
        pulse_load(1'b1);
        tick();
        checks++; if (in_ready4 !== 1'b0 || error4 !== 1'b1) begin errors++; $display("FAIL err_sticky got rdy=%b err=%b exp 0 1", in_ready4, error4); end
        reset4 = 1'b1; tick(); reset4 = 1'b0;
        checks++; if (error4 !== 1'b0 || cpu_hold4 !== 1'b1) begin errors++; $display("FAIL ovf_reset got err=%b hold=%b exp 0 1", error4, cpu_hold4); end
        clear_logs();
        pulse_load(1'b1);
        stream(4, 3, 1'b0, 1'b1);
        repeat (4) tick();
        checks++; if (done4 !== 1'b1 || error4 !== 1'b0 || cpu_hold4 !== 1'b0) begin errors++; $display("FAIL full_last got done=%b err=%b hold=%b exp 1 0 0", done4, error4, cpu_hold4); end
        checks++; if (start4_n != 1 || word_count4 !== 3'd4) begin errors++; $display("FAIL full_last_start got %0d starts count %0d exp 1 4", start4_n, word_count4); end
    endtask

    task automatic test_reset_mid_load();
        load_demo();
        clear_logs();
        pulse_load(1'b0);
        stream(2, -1, 1'b0, 1'b0);
        checks++; if (mem_we !== 1'b1 || word_count !== 11'd2) begin errors++; $display("FAIL mid_pre got we=%b count=%0d exp 1 2", mem_we, word_count); end
        reset = 1'b1; tick(); reset = 1'b0;
        checks++; if (mem_we !== 1'b0 || mem_addr !== 10'd0 || mem_wdata !== 32'd0) begin errors++; $display("FAIL mid_rst_mem got %b %h %h exp 0 0 0", mem_we, mem_addr, mem_wdata); end
        checks++; if (word_count !== 11'd0 || cpu_hold !== 1'b1 || in_ready !== 1'b0 || done !== 1'b0 || cpu_start !== 1'b0) begin
            errors++; $display("FAIL mid_rst_ctl got cnt=%0d hold=%b rdy=%b done=%b start=%b exp 0 1 0 0 0", word_count, cpu_hold, in_ready, done, cpu_start);
        end
        clear_logs();
        prog[0] = 32'hfc000000;
        pulse_load(1'b0);
        stream(1, -1, 1'b0, 1'b0);
        repeat (4) tick();
        checks++; if (wr_addr.size() != 1 || (wr_addr.size() == 1 && wr_addr[0] !== 10'd0)) begin errors++; $display("FAIL mid_restart got %0d writes exp 1 at addr 0", wr_addr.size()); end
        checks++; if (word_count !== 11'd1 || done !== 1'b1) begin errors++; $display("FAIL mid_restart_done got cnt=%0d done=%b exp 1 1", word_count, done); end
    endtask

    task automatic test_reload();
        clear_logs();
        pulse_load(1'b0);
        checks++; if (cpu_hold !== 1'b1 || done !== 1'b0 || word_count !== 11'd0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL reload_enter got hold=%b done=%b cnt=%0d rdy=%b exp 1 0 0 1", cpu_hold, done, word_count, in_ready);
        end
        prog[0] = 32'h2801000a; prog[1] = 32'hfc000000;
        stream(2, -1, 1'b0, 1'b0);
        repeat (4) tick();
        checks++; if (word_count !== 11'd2) begin errors++; $display("FAIL reload_count got %0d exp 2", word_count); end
        checks++; if (wr_addr.size() != 2 || (wr_addr.size() == 2 && wr_addr[1] !== 10'd1)) begin errors++; $display("FAIL reload_writes got %0d exp 2", wr_addr.size()); end
        checks++; if (start_cyc.size() != 1 || done !== 1'b1 || cpu_hold !== 1'b0) begin errors++; $display("FAIL reload_release got starts=%0d done=%b hold=%b exp 1 1 0", start_cyc.size(), done, cpu_hold); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; reset4 = 1'b1; load_req = 1'b0; load_req4 = 1'b0;
        in_valid = 1'b0; in_last = 1'b0; in_data = 32'd0;
        for (int i = 0; i < 16; i++) prog[i] = 32'd0;
        @(negedge clk1);
        test_reset();
        test_hlt_load(1'b0, "hlt");
        test_hlt_load(1'b1, "toggle");
        test_last3();
        test_overflow();
        test_reset_mid_load();
        test_reload();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
